// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle RV32I core: Moore controls per step,
// memory handshake via mem_ready, retired-instruction count and illegal-op flag.
module mc_main_fsm #(
  parameter int unsigned RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic [RET_W-1:0] instret
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  state_e           state_q, state_d;
  logic [RET_W-1:0] instret_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + RET_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpI:        state_d = StExecuteI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default: begin
            // Unsupported op is dropped as a NOP and never retires.
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        state_d = StFetch;
        retire  = 1'b1;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_d  = StAluWb;
      end
      default: begin
        // FETCH, and recovery from unused encodings with FETCH outputs.
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        if (state_q != StFetch) state_d = StFetch;
        else if (mem_ready)     state_d = StDecode;
      end
    endcase
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm.
module tb_mc_main_fsm;

  logic        clk = 1'b0;
  logic        reset, mem_ready;
  logic [6:0]  op;
  logic        PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  state_o;
  logic [31:0] instret;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ret  = 0;

  mc_main_fsm #(.RET_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .state_o   (state_o),
    .illegal_op(illegal_op),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b0; op = 7'd0;
    repeat (2) tick();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state_o !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_o);
    else n_pass++;
    n_checks++;
    if (instret !== 32'd0) $display("FAIL reset_instret: got %0d want 0", instret);
    else n_pass++;
    n_checks++;
    if ({IRWrite, PCUpdate, ALUSrcB, ResultSrc} !== 6'b11_10_10)
      $display("FAIL reset_fetch_outs: got %b want 111010",
               {IRWrite, PCUpdate, ALUSrcB, ResultSrc});
    else n_pass++;
    exp_ret = 0;
  endtask

  task automatic test_fetch_stall();
    logic [3:0] st;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({IRWrite, PCUpdate} !== 2'b00) $display("FAIL stall_gating: got %b want 00",
                                                 {IRWrite, PCUpdate});
    else n_pass++;
    tick();
    st = state_o;
    n_checks++;
    if (st !== 4'd0) $display("FAIL stall_hold: got %0d want 0", st);
    else n_pass++;
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    op = 7'b0110011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) $display("FAIL rtype_state[%0d]: got %0d want %0d",
                                          i, state_o, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (RegWrite !== (i == 3)) $display("FAIL rtype_regwrite[%0d]: got %b want %b",
                                          i, RegWrite, (i == 3));
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b10_00_10)
          $display("FAIL rtype_exec_outs: got %b want 100010", {ALUSrcA, ALUSrcB, ALUOp});
        else n_pass++;
      end
      if (i < 4) tick();
    end
    exp_ret++;
    n_checks++;
    if (instret !== exp_ret) $display("FAIL rtype_instret: got %0d want %0d", instret, exp_ret);
    else n_pass++;
  endtask

  task automatic test_itype();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    op = 7'b0010011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) $display("FAIL itype_state[%0d]: got %0d want %0d",
                                          i, state_o, exp_st[i]);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b10_01_10)
          $display("FAIL itype_exec_outs: got %b want 100110", {ALUSrcA, ALUSrcB, ALUOp});
        else n_pass++;
      end
      if (i < 4) tick();
    end
    exp_ret++;
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       mr     [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) $display("FAIL lw_state[%0d]: got %0d want %0d",
                                          i, state_o, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (AdrSrc !== (exp_st[i] == 4'd3)) $display("FAIL lw_adrsrc[%0d]: got %b want %b",
                                                   i, AdrSrc, (exp_st[i] == 4'd3));
      else n_pass++;
      if (exp_st[i] == 4'd4) begin
        n_checks++;
        if ({RegWrite, ResultSrc} !== 3'b1_01)
          $display("FAIL lw_memwb_outs: got %b want 101", {RegWrite, ResultSrc});
        else n_pass++;
      end
      if (i < 7) tick();
    end
    exp_ret++;
    n_checks++;
    if (instret !== exp_ret) $display("FAIL lw_instret: got %0d want %0d", instret, exp_ret);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd9, 4'd0};
    int mw_cnt = 0;
    int br_cnt = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = (i < 4) ? 7'b0100011 : 7'b1100011;
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) $display("FAIL swbeq_state[%0d]: got %0d want %0d",
                                          i, state_o, exp_st[i]);
      else n_pass++;
      if (MemWrite) mw_cnt++;
      if (Branch) begin
        br_cnt++;
        n_checks++;
        if (ALUOp !== 2'b01) $display("FAIL beq_aluop: got %b want 01", ALUOp);
        else n_pass++;
      end
      if (i < 7) tick();
    end
    n_checks++;
    if (mw_cnt != 1) $display("FAIL sw_memwrite_cycles: got %0d want 1", mw_cnt);
    else n_pass++;
    n_checks++;
    if (br_cnt != 1) $display("FAIL beq_branch_cycles: got %0d want 1", br_cnt);
    else n_pass++;
    exp_ret += 2;
    n_checks++;
    if (instret !== exp_ret) $display("FAIL swbeq_instret: got %0d want %0d", instret, exp_ret);
    else n_pass++;
  endtask

  task automatic test_jal_illegal();
    logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0, 4'd1, 4'd0};
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = (i < 4) ? 7'b1101111 : 7'b0000000;
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) $display("FAIL jal_state[%0d]: got %0d want %0d",
                                          i, state_o, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (illegal_op !== (i == 5)) $display("FAIL illegal_pulse[%0d]: got %b want %b",
                                            i, illegal_op, (i == 5));
      else n_pass++;
      n_checks++;
      if (PCUpdate !== (exp_st[i] == 4'd0 || exp_st[i] == 4'd10))
        $display("FAIL jal_pcupdate[%0d]: got %b want %b", i, PCUpdate,
                 (exp_st[i] == 4'd0 || exp_st[i] == 4'd10));
      else n_pass++;
      if (i < 6) tick();
    end
    exp_ret++;
    n_checks++;
    if (instret !== exp_ret) $display("FAIL jal_instret: got %0d want %0d", instret, exp_ret);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    op = 7'b0100011; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state_o, MemWrite} !== 5'b0101_1)
      $display("FAIL midwr_pre: got %b want 01011", {state_o, MemWrite});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 4'd0) $display("FAIL midwr_state: got %0d want 0", state_o);
    else n_pass++;
    n_checks++;
    if (MemWrite !== 1'b0) $display("FAIL midwr_memwrite: got %b want 0", MemWrite);
    else n_pass++;
    n_checks++;
    if (instret !== 32'd0) $display("FAIL midwr_instret: got %0d want 0", instret);
    else n_pass++;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_rtype();
    test_itype();
    test_lw_stall();
    test_back_to_back();
    test_jal_illegal();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
